// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the gate truth-table checker.
//   state_t   : checker FSM states
//   IDX_*     : bit positions inside the 7-bit response bundle (bit 6 = AND)
//   golden()  : expected response bundle for one {a,b} input vector
package gate_chk_pkg;

  localparam int RESP_BITS = 7;

  localparam int IDX_AND  = 6;
  localparam int IDX_OR   = 5;
  localparam int IDX_NOTA = 4;
  localparam int IDX_NAND = 3;
  localparam int IDX_NOR  = 2;
  localparam int IDX_XOR  = 1;
  localparam int IDX_XNOR = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Golden response built from the gate definitions themselves, so the
  // table cannot drift from what each function really computes.
  function automatic logic [RESP_BITS-1:0] golden(input logic a, input logic b);
    logic [RESP_BITS-1:0] g;
    g           = '0;
    g[IDX_AND]  = a & b;
    g[IDX_OR]   = a | b;
    g[IDX_NOTA] = ~a;
    g[IDX_NAND] = ~(a & b);
    g[IDX_NOR]  = ~(a | b);
    g[IDX_XOR]  = a ^ b;
    g[IDX_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Bus between the checker and its environment (gate block + controller).
//   start/busy/done/pass       : sweep handshake and verdict
//   drive_a/drive_b            : stimulus to the gate block
//   resp[6:0]                  : gate outputs {D,O,NT,ND,NR,XR,XN}
//   err_count/first_fail_vec   : sweep result detail
//   fail_mask[6:0]             : only with GATE_CHK_FAILMASK_EN defined
// modport master = checker side, slave = environment side.
interface gate_truth_table_checker_if;
  import gate_chk_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 drive_a;
  logic                 drive_b;
  logic [RESP_BITS-1:0] resp;
  logic [2:0]           err_count;
  logic [1:0]           first_fail_vec;
`ifdef GATE_CHK_FAILMASK_EN
  logic [RESP_BITS-1:0] fail_mask;
`endif

  modport master (
    input  start, resp,
    output busy, done, pass, drive_a, drive_b, err_count, first_fail_vec
`ifdef GATE_CHK_FAILMASK_EN
    , output fail_mask
`endif
  );

  modport slave (
    output start, resp,
    input  busy, done, pass, drive_a, drive_b, err_count, first_fail_vec
`ifdef GATE_CHK_FAILMASK_EN
    , input fail_mask
`endif
  );

endinterface

// File: rtl/gate_truth_table_checker_model.sv
// Combinational golden model of the 7-function gate block.
//   a, b      : input vector
//   expected  : expected {D,O,NT,ND,NR,XR,XN}
// 00->0011101  01->0111010  10->0101010  11->1100001
module gate_expected_model
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [RESP_BITS-1:0] expected
);

  assign expected = golden(a, b);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps the gate block through {A,B} = 00,01,10,11, holds each vector for
// SETTLE_CYCLES cycles, samples resp and compares it against the golden
// model. Reports pass, mismatching-vector count and first failing vector.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : gate_truth_table_checker_if.master (handshake, drive, resp, results)
// Optional: GATE_CHK_FAILMASK_EN adds bus.fail_mask (sticky per-gate errors).
// Latency start->done = 1 + 4*(SETTLE_CYCLES+2) cycles.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2,   // 1..15
  parameter int RESP_W        = 7    // fixed at 7
) (
  input  logic                         clk,
  input  logic                         rst,
  gate_truth_table_checker_if.master   bus
);
  import gate_chk_pkg::*;

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [3:0]        cnt;
  logic              drive_a, drive_b;
  logic [2:0]        err_count;
  logic [1:0]        first_fail_vec;
  logic              pass;
  logic [RESP_W-1:0] expected;
  logic              mismatch;
`ifdef GATE_CHK_FAILMASK_EN
  logic [RESP_W-1:0] fail_mask;
`endif

  gate_expected_model u_model (
    .a        (drive_a),
    .b        (drive_b),
    .expected (expected)
  );

  // Case-inequality so X/Z on resp is a mismatch.
  assign mismatch = (bus.resp !== expected);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_DRIVE;
      ST_DRIVE:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (idx == 2'd3) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      ST_DRIVE, ST_SETTLE, ST_SAMPLE: bus.busy = 1'b1;
      ST_DONE:                        bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: stimulus, settle counter, result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      cnt            <= '0;
      drive_a        <= 1'b0;
      drive_b        <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
`ifdef GATE_CHK_FAILMASK_EN
      fail_mask      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          idx            <= '0;
          err_count      <= '0;
          first_fail_vec <= '0;
          pass           <= 1'b0;
`ifdef GATE_CHK_FAILMASK_EN
          fail_mask      <= '0;
`endif
        end
        ST_DRIVE: begin
          {drive_a, drive_b} <= idx;
          cnt                <= 4'(SETTLE_CYCLES - 1);
        end
        ST_SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 3'd1;
            if (err_count == 3'd0) first_fail_vec <= {drive_a, drive_b};
          end
`ifdef GATE_CHK_FAILMASK_EN
          fail_mask <= fail_mask | (bus.resp ^ expected);
`endif
          // Verdict is resolved on the last sample so it is already
          // valid while done is high.
          if (idx == 2'd3) pass <= (err_count == 3'd0) && !mismatch;
          else             idx  <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.drive_a        = drive_a;
  assign bus.drive_b        = drive_b;
  assign bus.err_count      = err_count;
  assign bus.first_fail_vec = first_fail_vec;
  assign bus.pass           = pass;
`ifdef GATE_CHK_FAILMASK_EN
  assign bus.fail_mask      = fail_mask;
`endif

endmodule
